// File: rtl/blink_pkg.sv
// Shared types, default timing constants and the round-robin helper
// used by the status-LED blink arbiter.
package blink_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ON,
    S_OFF,
    S_GAP
  } state_t;

  // Defaults give 0.5 ms ticks from a 50 MHz clock.
  localparam int DEF_TICK_DIV  = 25000;
  localparam int DEF_ON_TICKS  = 200;
  localparam int DEF_OFF_TICKS = 200;
  localparam int DEF_GAP_TICKS = 1000;

  // Returns the first set request after ptr, wrapping around n requesters.
  // The scan runs from the farthest candidate to the nearest so that the
  // nearest set bit is the last one written and therefore wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int         n);
    logic [2:0] win;
    int         idx;
    win = ptr;
    for (int i = n; i >= 1; i--) begin
      idx = (int'(ptr) + i) % n;
      if (req[idx]) win = 3'(idx);
    end
    return win;
  endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Prescaler for the blink timing: counts 0..TICK_DIV-1 and flags the
// terminal count. A synchronous restart realigns the tick phase.
module blink_tick_gen #(
  parameter int TICK_DIV = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int              PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;

  // Free-running prescaler that wraps exactly at its terminal count.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      presc <= '0;
    end else if (presc == LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign tick = (presc == LAST);

endmodule

// File: rtl/led_blink_arbiter.sv
// Shares the active-low board status LED between N_REQ requesters.
// Requesters are granted round-robin; the winner's blink code is played as
// a series of ON/OFF flashes followed by a dark gap, then Done pulses.
module led_blink_arbiter import blink_pkg::*; #(
  parameter int N_REQ     = 4,
  parameter int CNT_W     = 4,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic                   Clk50M,
  input  logic                   Rst,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*CNT_W-1:0] Blink_cnt,
  output logic [N_REQ-1:0]       Gnt,
  output logic [N_REQ-1:0]       Done,
  output logic                   Busy,
  output logic                   FPGA_LEDG
);

  localparam int MAX_OG = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_T  = (MAX_OG > GAP_TICKS) ? MAX_OG : GAP_TICKS;
  localparam int TMR_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int PTR_W  = $clog2(N_REQ);

  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_TICKS - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_TICKS - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_TICKS - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win;
  logic [TMR_W-1:0]   timer;
  logic [CNT_W-1:0]   bcnt;
  logic               tick;
  logic               restart;

  assign win     = PTR_W'(rr_pick(8'(Req), 3'(rr_ptr), N_REQ));
  assign restart = (state == S_LOAD);

  blink_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (Clk50M),
    .rst     (Rst),
    .restart (restart),
    .tick    (tick)
  );

  // Arbitration and blink-code FSM; all outputs are registered here.
  always_ff @(posedge Clk50M) begin
    if (Rst) begin
      state     <= S_IDLE;
      rr_ptr    <= PTR_W'(N_REQ - 1);
      timer     <= '0;
      Gnt       <= '0;
      Done      <= '0;
      Busy      <= 1'b0;
      FPGA_LEDG <= 1'b1;
    end else begin
      Done <= '0;
      case (state)
        S_IDLE: begin
          if (|Req) begin
            rr_ptr <= win;
            Gnt    <= ONE_HOT0 << win;
            bcnt   <= Blink_cnt[win*CNT_W +: CNT_W];
            Busy   <= 1'b1;
            timer  <= '0;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          timer <= '0;
          if (bcnt == '0) begin
            state <= S_GAP;
          end else begin
            FPGA_LEDG <= 1'b0;
            state     <= S_ON;
          end
        end
        S_ON: begin
          if (tick) begin
            if (timer == ON_LAST) begin
              timer     <= '0;
              FPGA_LEDG <= 1'b1;
              bcnt      <= bcnt - CNT_W'(1);
              state     <= (bcnt != CNT_W'(1)) ? S_OFF : S_GAP;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
        end
        S_OFF: begin
          if (tick) begin
            if (timer == OFF_LAST) begin
              timer     <= '0;
              FPGA_LEDG <= 1'b0;
              state     <= S_ON;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (timer == GAP_LAST) begin
              timer <= '0;
              Done  <= Gnt;
              Gnt   <= '0;
              Busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Scoreboard bench for led_blink_arbiter with fast timing parameters:
// one flash = 8 cycles low, inter-flash = 4 cycles high, gap = 12 cycles.
module tb_led_blink_arbiter;

  localparam int N_REQ = 4;
  localparam int CNT_W = 4;

  typedef struct {
    logic [N_REQ-1:0] done;
    int               flashes;
    int               dur;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] bcnt;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic                   led;

  int checks = 0;
  int errors = 0;

  exp_t             exp_q[$];
  logic [N_REQ-1:0] gnt_q[$];

  led_blink_arbiter #(
    .N_REQ     (N_REQ),
    .CNT_W     (CNT_W),
    .TICK_DIV  (4),
    .ON_TICKS  (2),
    .OFF_TICKS (1),
    .GAP_TICKS (3)
  ) dut (
    .Clk50M    (clk),
    .Rst       (rst),
    .Req       (req),
    .Blink_cnt (bcnt),
    .Gnt       (gnt),
    .Done      (done),
    .Busy      (busy),
    .FPGA_LEDG (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks each granted code and compares against the scoreboard.
  logic [N_REQ-1:0] cur_gnt = '0;
  int  dur = 0, flashes = 0, low_run = 0;
  bit  gnt_stable = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    logic [N_REQ-1:0] eg;
    if (done != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got %b, no completion expected", done);
      end else begin
        e = exp_q.pop_front();
        check("done_bits", int'(done), int'(e.done));
        check("flash_count", flashes, e.flashes);
        check("code_cycles", dur, e.dur);
        check("gnt_stable", int'(gnt_stable), 1);
      end
      cur_gnt = '0;
    end else if (gnt == '0 && cur_gnt != '0) begin
      cur_gnt = '0;
      low_run = 0;
    end
    if (gnt != '0 && cur_gnt == '0) begin
      if (gnt_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got %b, no grant expected", gnt);
      end else begin
        eg = gnt_q.pop_front();
        check("grant", int'(gnt), int'(eg));
      end
      cur_gnt    = gnt;
      dur        = 0;
      flashes    = 0;
      gnt_stable = 1'b1;
    end
    if (cur_gnt != '0) begin
      dur++;
      if (gnt != cur_gnt) gnt_stable = 1'b0;
    end
    if (led === 1'b0) begin
      if (low_run == 0) flashes++;
      low_run++;
    end else if (low_run > 0) begin
      check("on_len", low_run, 8);
      low_run = 0;
    end
  end

  task automatic push(input logic [N_REQ-1:0] g, input int n, input int d);
    exp_t e;
    e.done = g; e.flashes = n; e.dur = d;
    gnt_q.push_back(g);
    exp_q.push_back(e);
  endtask

  task automatic wait_done(output logic [N_REQ-1:0] d);
    d = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done != '0) begin
        d = done;
        return;
      end
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic wait_led(input logic v);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (led === v) return;
    end
    check("led_timeout", int'(led), int'(v));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [N_REQ-1:0] d;
  bit               saw_done;

  initial begin
    rst  = 1'b1;
    req  = '0;
    bcnt = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_led", int'(led), 1);
    check("rst_gnt", int'(gnt), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // 1: single requester, three flashes; also latency of grant and LED
    bcnt = 16'h0003;
    push(4'b0001, 3, 45);
    req = 4'b0001;
    @(negedge clk);
    check("lat_gnt", int'(gnt), 1);
    check("lat_led_dark", int'(led), 1);
    check("lat_busy", int'(busy), 1);
    @(negedge clk);
    check("lat_led_lit", int'(led), 0);
    wait_done(d);
    req = '0;
    check("t1_busy_after", int'(busy), 0);
    check("t1_led_after", int'(led), 1);

    // 2: all requesting from reset, one flash each; order 0,1,2,3,0
    do_reset();
    bcnt = 16'h1111;
    push(4'b0001, 1, 21);
    push(4'b0010, 1, 21);
    push(4'b0100, 1, 21);
    push(4'b1000, 1, 21);
    push(4'b0001, 1, 21);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_done(d);
    req = '0;

    // 3: zero-count code: no flash, gap only
    bcnt = 16'h0000;
    push(4'b0100, 0, 13);
    req = 4'b0100;
    wait_done(d);
    req = '0;
    repeat (3) @(negedge clk);
    check("t3_busy", int'(busy), 0);
    check("t3_gnt", int'(gnt), 0);

    // 4: reset in the middle of the first flash of a 5-flash code
    bcnt = 16'h0005;
    gnt_q.push_back(4'b0001);
    req = 4'b0001;
    wait_led(1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_led", int'(led), 1);
    check("abort_gnt", int'(gnt), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done != '0) saw_done = 1'b1;
    end
    check("abort_no_done", int'(saw_done), 0);
    bcnt = 16'h0000;
    push(4'b0001, 0, 13);
    push(4'b0010, 0, 13);
    req = 4'b0011;
    wait_done(d);
    req = 4'b0010;
    wait_done(d);
    req = '0;

    // 5: 15 flashes; count field rewritten after grant must be ignored
    bcnt = 16'h000F;
    push(4'b0001, 15, 189);
    req = 4'b0001;
    @(negedge clk);
    bcnt = 16'h0001;
    wait_done(d);
    req = '0;

    // 6: request withdrawn during OFF; code still completes
    bcnt = 16'h0002;
    push(4'b0001, 2, 33);
    req = 4'b0001;
    wait_led(1'b0);
    wait_led(1'b1);
    req = '0;
    wait_done(d);
    repeat (3) @(negedge clk);
    check("t6_busy", int'(busy), 0);
    check("t6_gnt", int'(gnt), 0);

    repeat (4) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("gnt_q_empty", gnt_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
